// File: rtl/gate_sweep_unit_if.sv
// Control and result bundle for gate_sweep_unit: sweep control in, stimulus and measurement out.
`timescale 1ns/1ps
interface gate_sweep_unit_if #(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned CNT_W = N_IN + 1
);
    logic             start;
    logic [1:0]       mode;
    logic             step_en;
    logic             abort;
    logic [N_IN-1:0]  in_vec;
    logic             y;
    logic             y_valid;
    logic [CNT_W-1:0] ones_cnt;
    logic             busy;
    logic             done;

    modport master (
        output start, mode, step_en, abort,
        input  in_vec, y, y_valid, ones_cnt, busy, done
    );

    modport slave (
        input  start, mode, step_en, abort,
        output in_vec, y, y_valid, ones_cnt, busy, done
    );
endinterface

// File: rtl/gate_sweep_unit.sv
// Exhaustive N-input gate sweep: counts through all input vectors, applies a selectable
// reduction, registers the result and tallies how many vectors produced a 1.
`timescale 1ns/1ps
module gate_sweep_unit #(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned CNT_W = N_IN + 1
) (
    input logic            clk,
    input logic            reset_n,
    gate_sweep_unit_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [1:0] M_AND  = 2'b00;
    localparam logic [1:0] M_OR   = 2'b01;
    localparam logic [1:0] M_XOR  = 2'b10;

    localparam logic [N_IN-1:0] VEC_MAX = '1;

    logic [1:0]       state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic             y_q, y_d;
    logic             yv_q, yv_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             red_c;

    // Reduction of the vector currently presented, under the latched mode.
    always_comb begin
        case (mode_q)
            M_AND:   red_c = &vec_q;
            M_OR:    red_c = |vec_q;
            M_XOR:   red_c = ^vec_q;
            default: red_c = ~&vec_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            mode_q  <= 2'b00;
            vec_q   <= '0;
            y_q     <= 1'b0;
            yv_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            vec_q   <= vec_d;
            y_q     <= y_d;
            yv_q    <= yv_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        vec_d   = vec_q;
        y_d     = y_q;
        yv_d    = 1'b0;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mode_d  = bus.mode;
                    vec_d   = '0;
                    cnt_d   = '0;
                    y_d     = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_SWEEP;
                end
            end
            S_SWEEP: begin
                // abort wins over step_en; partial count is left visible
                if (bus.abort) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (bus.step_en) begin
                    y_d   = red_c;
                    yv_d  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(red_c);
                    if (vec_q != VEC_MAX) begin
                        vec_d = vec_q + N_IN'(1);
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.in_vec   = vec_q;
    assign bus.y        = y_q;
    assign bus.y_valid  = yv_q;
    assign bus.ones_cnt = cnt_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule
